// File: rtl/csa_modq_resolve_if.sv
// Handshake and data bundle for csa_modq_resolve.
// The master side drives the rows and o_ready. The slave side (the resolver) drives the results.
// Optional raw_o bus is present only when CSA_RESOLVE_RAW_OUT_EN is defined.
interface csa_modq_resolve_if #(
  parameter int W  = 15,
  parameter int QW = 12
);
  logic [W-1:0]  s_i;
  logic [W-1:0]  c_i;
  logic          i_valid;
  logic          i_ready;
  logic [QW-1:0] r_o;
  logic          o_valid;
  logic          o_ready;
  logic [15:0]   o_count;
`ifdef CSA_RESOLVE_RAW_OUT_EN
  logic [W:0]    raw_o;
`endif

  modport master (
    output s_i, c_i, i_valid, o_ready,
`ifdef CSA_RESOLVE_RAW_OUT_EN
    input  raw_o,
`endif
    input  i_ready, r_o, o_valid, o_count
  );

  modport slave (
    input  s_i, c_i, i_valid, o_ready,
`ifdef CSA_RESOLVE_RAW_OUT_EN
    output raw_o,
`endif
    output i_ready, r_o, o_valid, o_count
  );
endinterface

// File: rtl/csa_modq_resolve.sv
// csa_modq_resolve: resolves one carry-save row pair and reduces the sum mod Q.
// The block is a 3-stage valid/ready pipeline with bubble collapsing.
//   S1: x1 = s + c (W+1 bits)
//   S2: fold the bits above QW using 2^QW mod Q, giving x2 = hi*FOLD + lo
//   S3: subtract k*Q, where k is picked by parallel compares against 1Q..K_MAX*Q
// Optional feature macro: CSA_RESOLVE_RAW_OUT_EN. It adds raw_o, the unreduced sum carried alongside r_o.
module csa_modq_resolve #(
  parameter int W  = 15,
  parameter int Q  = 3329,
  parameter int QW = 12
) (
  input  logic             clk,
  input  logic             reset,
  csa_modq_resolve_if.slave bus
);

  // Fold constant and worst-case sizes, all derived from W/Q/QW.
  localparam int FOLD   = (1 << QW) % Q;
  localparam int X1_MAX = (1 << (W + 1)) - 2;
  localparam int HI_MAX = X1_MAX >> QW;
  localparam int X2_MAX = HI_MAX * FOLD + (1 << QW) - 1;
  localparam int K_MAX  = X2_MAX / Q;
  localparam int X2W    = $clog2(X2_MAX + 1);
  localparam int HW     = W + 1 - QW;
  localparam logic [X2W-1:0] FOLD_X = X2W'(FOLD);

  // Stage valids and data registers.
  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [W:0]      x1_q, x1_d;
  logic [X2W-1:0]  x2_q, x2_d;
  logic [QW-1:0]   r_q, r_d;
  logic [15:0]     cnt_q, cnt_d;
`ifdef CSA_RESOLVE_RAW_OUT_EN
  logic [W:0]      raw2_q, raw2_d, raw3_q, raw3_d;
`endif

  // Per-stage load enables and transfer strobes.
  logic            en1_s, en2_s, en3_s;
  logic            in_xfer_s, out_xfer_s;
  logic [W:0]      x1_sum_s;
  logic [HW-1:0]   hi_s;
  logic [QW-1:0]   lo_s;
  logic [X2W-1:0]  x2_sum_s;
  logic [X2W-1:0]  r_fold_s;

  // Each stage may load when empty, or when its content moves on this cycle.
  // i_ready therefore depends on o_ready but never on i_valid.
  assign en3_s      = !v3_q | bus.o_ready;
  assign en2_s      = !v2_q | en3_s;
  assign en1_s      = !v1_q | en2_s;
  assign in_xfer_s  = bus.i_valid & en1_s;
  assign out_xfer_s = v3_q & bus.o_ready;

  // S1 datapath: carry-propagate add of the aligned rows.
  assign x1_sum_s = {1'b0, bus.s_i} + {1'b0, bus.c_i};

  // S2 datapath: 2^QW == FOLD (mod Q), so the high part is folded down.
  assign hi_s     = x1_q[W:QW];
  assign lo_s     = x1_q[QW-1:0];
  assign x2_sum_s = X2W'(hi_s) * FOLD_X + X2W'(lo_s);

  // S3 datapath: the compares are thermometer-coded, so the highest j with x2 >= j*Q wins.
  always_comb begin
    r_fold_s = x2_q;
    for (int j = 1; j <= K_MAX; j++) begin
      r_fold_s = (x2_q >= X2W'(j * Q)) ? (x2_q - X2W'(j * Q)) : r_fold_s;
    end
  end

  // Next-state logic: valids follow the enables, and data loads only on a real transfer.
  always_comb begin
    v1_d  = en1_s ? bus.i_valid : v1_q;
    v2_d  = en2_s ? v1_q : v2_q;
    v3_d  = en3_s ? v2_q : v3_q;
    x1_d  = in_xfer_s ? x1_sum_s : x1_q;
    x2_d  = (en2_s & v1_q) ? x2_sum_s : x2_q;
    r_d   = (en3_s & v2_q) ? r_fold_s[QW-1:0] : r_q;
    cnt_d = out_xfer_s ? (cnt_q + 16'd1) : cnt_q;
`ifdef CSA_RESOLVE_RAW_OUT_EN
    raw2_d = (en2_s & v1_q) ? x1_q : raw2_q;
    raw3_d = (en3_s & v2_q) ? raw2_q : raw3_q;
`endif
  end

  // Pipeline state registers. An asynchronous reset discards in-flight items.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      x1_q   <= '0;
      x2_q   <= '0;
      r_q    <= '0;
      cnt_q  <= 16'd0;
`ifdef CSA_RESOLVE_RAW_OUT_EN
      raw2_q <= '0;
      raw3_q <= '0;
`endif
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
`ifdef CSA_RESOLVE_RAW_OUT_EN
      raw2_q <= raw2_d;
      raw3_q <= raw3_d;
`endif
    end
  end

  assign bus.i_ready = en1_s;
  assign bus.o_valid = v3_q;
  assign bus.r_o     = r_q;
  assign bus.o_count = cnt_q;
`ifdef CSA_RESOLVE_RAW_OUT_EN
  assign bus.raw_o   = raw3_q;
`endif

endmodule
